// File: rtl/mem_pkg.sv
// Load-path encodings, bus size codes, FSM state codes and address helpers.
// Shared by the load read unit and its extension datapath.
package mem_pkg;

  localparam logic [2:0] LD_LW  = 3'b001;
  localparam logic [2:0] LD_LH  = 3'b010;
  localparam logic [2:0] LD_LHU = 3'b011;
  localparam logic [2:0] LD_LB  = 3'b100;
  localparam logic [2:0] LD_LBU = 3'b101;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  function automatic logic is_load(input logic [2:0] con);
    case (con)
      LD_LW, LD_LH, LD_LHU, LD_LB, LD_LBU: is_load = 1'b1;
      default:                             is_load = 1'b0;
    endcase
  endfunction

  function automatic logic [1:0] load_size(input logic [2:0] con);
    case (con)
      LD_LW:         load_size = SIZE_WORD;
      LD_LH, LD_LHU: load_size = SIZE_HALF;
      default:       load_size = SIZE_BYTE;
    endcase
  endfunction

  // Low address bits as sent on the bus: words and halves are naturally aligned.
  function automatic logic [1:0] align_off(input logic [2:0] con, input logic [1:0] off);
    case (con)
      LD_LW:         align_off = 2'b00;
      LD_LH, LD_LHU: align_off = {off[1], 1'b0};
      default:       align_off = off;
    endcase
  endfunction

  function automatic logic is_misaligned(input logic [2:0] con, input logic [1:0] off);
    case (con)
      LD_LW:         is_misaligned = (off != 2'b00);
      LD_LH, LD_LHU: is_misaligned = off[0];
      default:       is_misaligned = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_read_unit_if.sv
// SRAM-like data-bus read channel: req/addr accepted by addr_ok, data returned with data_ok.
// Master is the load unit; slave is the memory side.
interface load_read_unit_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);

  logic              data_req;
  logic [ADDR_W-1:0] data_addr;
  logic [1:0]        data_size;
  logic              data_addr_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              data_data_ok;

  modport master (
    output data_req, data_addr, data_size,
    input  data_addr_ok, data_rdata, data_data_ok
  );

  modport slave (
    input  data_req, data_addr, data_size,
    output data_addr_ok, data_rdata, data_data_ok
  );

endinterface

// File: rtl/load_extend.sv
// Combinational byte/halfword select with sign or zero extension for loads.
// Zero latency; no flow control.
module load_extend
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [2:0]  load_con,
  input  logic [1:0]  offset,
  output logic [31:0] data
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = rdata[{offset, 3'b000} +: 8];
    half_sel = rdata[{offset[1], 4'b0000} +: 16];
    case (load_con)
      LD_LH:   data = {{16{half_sel[15]}}, half_sel};
      LD_LHU:  data = {16'h0000, half_sel};
      LD_LB:   data = {{24{byte_sel[7]}}, byte_sel};
      LD_LBU:  data = {24'h000000, byte_sel};
      default: data = rdata;
    endcase
  end

endmodule

// File: rtl/load_read_unit.sv
// MEM-stage load unit: stalls until bus data returns, then extends and hands off with load_done (min 3 cycles).
// Stalls on bus handshake delays; LOAD_MISALIGN_EXC_EN raises adel on misaligned loads instead of aligning.
module load_read_unit
  import mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32  // extraction assumes a 32-bit data bus
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic [2:0]        load_con,
  input  logic [ADDR_W-1:0] addr,
  input  logic              flush,
  load_read_unit_if.master  bus,
  output logic [31:0]       rdata_out,
  output logic              load_done,
  output logic              stall,
  output logic              adel
);

  logic [1:0]        state;
  logic [1:0]        state_nxt;
  logic              discard;
  logic              discard_now;
  logic [2:0]        con_q;
  logic [ADDR_W-1:0] addr_q;
  logic [1:0]        size_q;
  logic [31:0]       ext_data;
  logic              start;
  logic              accept;
  logic [ADDR_W-1:0] addr_aligned;

  assign start = (state == ST_IDLE) && load && is_load(load_con) && !flush;

`ifdef LOAD_MISALIGN_EXC_EN
  logic misal;
  assign misal  = is_misaligned(load_con, addr[1:0]);
  assign adel   = start && misal;
  assign accept = start && !misal;
`else
  assign adel   = 1'b0;
  assign accept = start;
`endif

  assign addr_aligned = {addr[ADDR_W-1:2], align_off(load_con, addr[1:0])};

  // A flush arriving together with data_ok still kills the result.
  assign discard_now = discard || flush;

  always_comb begin
    state_nxt = state;
    case (state)
      ST_IDLE: if (accept) state_nxt = ST_REQ;
      ST_REQ: begin
        if (bus.data_addr_ok)  state_nxt = ST_WAIT;
        else if (flush)        state_nxt = ST_IDLE;
      end
      ST_WAIT: begin
        if (bus.data_data_ok)  state_nxt = discard_now ? ST_IDLE : ST_DONE;
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= ST_IDLE;
      discard <= 1'b0;
    end else begin
      state <= state_nxt;
      if (state == ST_REQ && bus.data_addr_ok && flush)
        discard <= 1'b1;
      else if (state == ST_WAIT)
        discard <= bus.data_data_ok ? 1'b0 : discard_now;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      addr_q <= '0;
      size_q <= SIZE_BYTE;
      con_q  <= 3'b000;
    end else if (accept) begin
      addr_q <= addr_aligned;
      size_q <= load_size(load_con);
      con_q  <= load_con;
    end
  end

  load_extend u_extend (
    .rdata    (bus.data_rdata[31:0]),
    .load_con (con_q),
    .offset   (addr_q[1:0]),
    .data     (ext_data)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      rdata_out <= 32'h0;
    else if (state == ST_WAIT && bus.data_data_ok && !discard_now)
      rdata_out <= ext_data;
  end

  assign bus.data_req  = (state == ST_REQ);
  assign bus.data_addr = addr_q;
  assign bus.data_size = size_q;
  assign load_done     = (state == ST_DONE);
  assign stall         = (state == ST_REQ) || (state == ST_WAIT) || accept;

endmodule

// File: tb/tb_load_read_unit.sv
// Scoreboarded bench for load_read_unit: bus responder with programmable addr_ok/data_ok delays.
// Build with +define+LOAD_MISALIGN_EXC_EN to exercise the misaligned-load exception path.
module tb_load_read_unit;
  import mem_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        load;
  logic [2:0]  load_con;
  logic [31:0] addr;
  logic        flush;
  logic [31:0] rdata_out;
  logic        load_done;
  logic        stall;
  logic        adel;

  always #5 clk = ~clk;

  load_read_unit_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  load_read_unit #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_con  (load_con),
    .addr      (addr),
    .flush     (flush),
    .bus       (bus),
    .rdata_out (rdata_out),
    .load_done (load_done),
    .stall     (stall),
    .adel      (adel)
  );

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mon_exp;

  int          o_lat, o_req, o_stall, o_done, o_adel;
  logic [31:0] o_addr;
  logic [1:0]  o_size;
  logic        o_last_stall;

  // Scoreboard: every load_done must match the oldest expected result.
  always begin
    @(negedge clk);
    #2;
    if (load_done === 1'b1) begin
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL scoreboard_unexpected: load_done with rdata_out=%h, no result expected", rdata_out);
      end else begin
        mon_exp = exp_q.pop_front();
        if (rdata_out !== mon_exp) begin
          n_fail++;
          $display("FAIL scoreboard_rdata: got %h expected %h", rdata_out, mon_exp);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [31:0] model(input logic [2:0] con, input logic [31:0] a, input logic [31:0] rd);
    logic [31:0] b, h;
    b = (rd >> (8 * a[1:0])) & 32'hFF;
    h = (rd >> (a[1] ? 16 : 0)) & 32'hFFFF;
    case (con)
      LD_LB:   model = b[7]  ? (b | 32'hFFFF_FF00) : b;
      LD_LBU:  model = b;
      LD_LH:   model = h[15] ? (h | 32'hFFFF_0000) : h;
      LD_LHU:  model = h;
      default: model = rd;
    endcase
  endfunction

  function automatic logic [1:0] exp_size(input logic [2:0] con);
    if (con == LD_LW) exp_size = 2'd2;
    else if (con == LD_LH || con == LD_LHU) exp_size = 2'd1;
    else exp_size = 2'd0;
  endfunction

  // Drives one load and a bus responder; addr_ok lands adly cycles into REQ, data_ok ddly cycles later.
  task automatic issue_load(input logic [2:0] con, input logic [31:0] a, input logic [31:0] rd,
                            input int adly, input int ddly, input int flush_at, input int ncyc);
    int limit;
    bit seen_req;
    o_lat = -1; o_req = 0; o_stall = 0; o_done = 0; o_adel = 0;
    o_addr = 32'h0; o_size = 2'd3; o_last_stall = 1'b0; seen_req = 0;
    limit = (ncyc > 0) ? ncyc : 60;
    for (int c = 0; c <= limit; c++) begin
      @(negedge clk);
      load     = (flush_at > 0) ? (c <= flush_at) : (o_done == 0);
      load_con = con;
      addr     = a;
      flush    = (flush_at > 0) && (c == flush_at);
      bus.data_addr_ok = (c == adly + 1);
      bus.data_data_ok = (c == adly + 1 + ddly);
      bus.data_rdata   = bus.data_data_ok ? rd : 32'hDEAD_BEEF;
      #1;
      if (bus.data_req) begin
        o_req++;
        if (!seen_req) begin
          seen_req = 1;
          o_addr = bus.data_addr;
          o_size = bus.data_size;
        end
      end
      if (stall) o_stall++;
      if (adel) o_adel++;
      o_last_stall = stall;
      if (load_done) begin
        o_done++;
        if (o_lat < 0) o_lat = c;
      end
      if (ncyc == 0 && o_lat >= 0 && c >= o_lat + 2) break;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; load = 1'b0; flush = 1'b0; load_con = 3'b000; addr = 32'h0;
    bus.data_addr_ok = 1'b0; bus.data_data_ok = 1'b0; bus.data_rdata = 32'h0;
    repeat (2) @(negedge clk);
    #1;
    n_checks++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL reset_req: got %b expected 0", bus.data_req); end
    n_checks++; if (bus.data_addr !== 32'h0) begin n_fail++; $display("FAIL reset_addr: got %h expected 0", bus.data_addr); end
    n_checks++; if (bus.data_size !== 2'd0) begin n_fail++; $display("FAIL reset_size: got %0d expected 0", bus.data_size); end
    n_checks++; if (rdata_out !== 32'h0) begin n_fail++; $display("FAIL reset_rdata: got %h expected 0", rdata_out); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b expected 0", load_done); end
    n_checks++; if (adel !== 1'b0) begin n_fail++; $display("FAIL reset_adel: got %b expected 0", adel); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b expected 0", stall); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_lb();
    exp_q.push_back(32'hFFFF_FF80);
    issue_load(LD_LB, 32'h0000_1003, 32'h80FF_1234, 0, 1, 0, 0);
    n_checks++; if (o_size !== 2'd0) begin n_fail++; $display("FAIL lb_size: got %0d expected 0", o_size); end
    n_checks++; if (o_addr !== 32'h0000_1003) begin n_fail++; $display("FAIL lb_addr: got %h expected 00001003", o_addr); end
    n_checks++; if (o_lat != 3) begin n_fail++; $display("FAIL lb_latency: got %0d expected 3", o_lat); end
    n_checks++; if (o_done != 1) begin n_fail++; $display("FAIL lb_done_count: got %0d expected 1", o_done); end
  endtask

  task automatic test_half();
    exp_q.push_back(32'h0000_8001);
    issue_load(LD_LHU, 32'h0000_2002, 32'h8001_0000, 0, 1, 0, 0);
    n_checks++; if (o_size !== 2'd1) begin n_fail++; $display("FAIL lhu_size: got %0d expected 1", o_size); end
    n_checks++; if (o_done != 1) begin n_fail++; $display("FAIL lhu_done_count: got %0d expected 1", o_done); end
    exp_q.push_back(32'hFFFF_8001);
    issue_load(LD_LH, 32'h0000_2002, 32'h8001_0000, 0, 1, 0, 0);
    n_checks++; if (o_size !== 2'd1) begin n_fail++; $display("FAIL lh_size: got %0d expected 1", o_size); end
    n_checks++; if (o_lat != 3) begin n_fail++; $display("FAIL lh_latency: got %0d expected 3", o_lat); end
  endtask

  task automatic test_patterns();
    logic [2:0]  cons[6] = '{LD_LBU, LD_LB,  LD_LH,  LD_LHU, LD_LW,  LD_LBU};
    logic [31:0] adrs[6] = '{32'h11, 32'h20, 32'h30, 32'h40, 32'h54, 32'h62};
    logic [31:0] rds[6]  = '{32'h0000_A500, 32'h0000_007F, 32'h1234_7FFF,
                             32'hFFFF_0000, 32'hCAFE_F00D, 32'h00C3_0000};
    logic [31:0] exps[6] = '{32'h0000_00A5, 32'h0000_007F, 32'h0000_7FFF,
                             32'h0000_0000, 32'hCAFE_F00D, 32'h0000_00C3};
    for (int i = 0; i < 6; i++) begin
      exp_q.push_back(exps[i]);
      issue_load(cons[i], adrs[i], rds[i], 0, 1, 0, 0);
      n_checks++; if (o_size !== exp_size(cons[i])) begin n_fail++; $display("FAIL pattern_size[%0d]: got %0d expected %0d", i, o_size, exp_size(cons[i])); end
      n_checks++; if (o_done != 1) begin n_fail++; $display("FAIL pattern_done[%0d]: got %0d expected 1", i, o_done); end
    end
  endtask

  task automatic test_random();
    logic [2:0]  con;
    logic [31:0] a, rd;
    int          ad, dd;
    for (int i = 0; i < 8; i++) begin
      con = 3'($urandom_range(1, 5));
      a   = $urandom();
      rd  = $urandom();
      if (con == LD_LW) a[1:0] = 2'b00;
      else if (con == LD_LH || con == LD_LHU) a[0] = 1'b0;
      ad = $urandom_range(0, 2);
      dd = $urandom_range(1, 3);
      exp_q.push_back(model(con, a, rd));
      issue_load(con, a, rd, ad, dd, 0, 0);
      n_checks++; if (o_lat != ad + dd + 2) begin n_fail++; $display("FAIL random_latency[%0d]: got %0d expected %0d", i, o_lat, ad + dd + 2); end
    end
  endtask

  task automatic test_delayed();
    exp_q.push_back(32'h0000_5A5A);
    issue_load(LD_LHU, 32'h0000_3000, 32'h1111_5A5A, 4, 3, 0, 0);
    n_checks++; if (o_req != 5) begin n_fail++; $display("FAIL delayed_req_cycles: got %0d expected 5", o_req); end
    n_checks++; if (o_stall != 9) begin n_fail++; $display("FAIL delayed_stall_cycles: got %0d expected 9", o_stall); end
    n_checks++; if (o_lat != 9) begin n_fail++; $display("FAIL delayed_latency: got %0d expected 9", o_lat); end
    n_checks++; if (o_done != 1) begin n_fail++; $display("FAIL delayed_done_count: got %0d expected 1", o_done); end
  endtask

  task automatic test_flush_addr_ok();
    issue_load(LD_LW, 32'h0000_4000, 32'h1111_1111, 1, 2, 2, 4);
    n_checks++; if (o_done != 0) begin n_fail++; $display("FAIL flush_aok_done: got %0d expected 0", o_done); end
    n_checks++; if (o_req != 2) begin n_fail++; $display("FAIL flush_aok_req: got %0d expected 2", o_req); end
    n_checks++; if (o_stall != 5) begin n_fail++; $display("FAIL flush_aok_stall: got %0d expected 5", o_stall); end
    exp_q.push_back(32'h0000_00C3);
    issue_load(LD_LBU, 32'h0000_4001, 32'h0000_C300, 0, 1, 0, 0);
    n_checks++; if (o_done != 1) begin n_fail++; $display("FAIL flush_aok_next_done: got %0d expected 1", o_done); end
    n_checks++; if (o_lat != 3) begin n_fail++; $display("FAIL flush_aok_next_latency: got %0d expected 3", o_lat); end
  endtask

  task automatic test_flush_req();
    issue_load(LD_LW, 32'h0000_5000, 32'h2222_2222, 50, 1, 1, 3);
    n_checks++; if (o_req != 1) begin n_fail++; $display("FAIL flush_req_req: got %0d expected 1", o_req); end
    n_checks++; if (o_done != 0) begin n_fail++; $display("FAIL flush_req_done: got %0d expected 0", o_done); end
    n_checks++; if (o_last_stall !== 1'b0) begin n_fail++; $display("FAIL flush_req_stall: got %b expected 0", o_last_stall); end
  endtask

  task automatic test_flush_wait();
    issue_load(LD_LW, 32'h0000_6000, 32'h3333_3333, 0, 3, 2, 4);
    n_checks++; if (o_done != 0) begin n_fail++; $display("FAIL flush_wait_done: got %0d expected 0", o_done); end
    exp_q.push_back(32'hCAFE_F00D);
    issue_load(LD_LW, 32'h0000_6004, 32'hCAFE_F00D, 0, 1, 0, 0);
    n_checks++; if (o_lat != 3) begin n_fail++; $display("FAIL flush_wait_next_latency: got %0d expected 3", o_lat); end
  endtask

  task automatic test_misalign();
`ifdef LOAD_MISALIGN_EXC_EN
    @(negedge clk);
    load = 1'b1; load_con = LD_LW; addr = 32'h0000_7002; flush = 1'b0;
    #1;
    n_checks++; if (adel !== 1'b1) begin n_fail++; $display("FAIL misalign_adel: got %b expected 1", adel); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL misalign_stall: got %b expected 0", stall); end
    @(negedge clk);
    load = 1'b0;
    #1;
    n_checks++; if (adel !== 1'b0) begin n_fail++; $display("FAIL misalign_adel_pulse: got %b expected 0", adel); end
    n_checks++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL misalign_req: got %b expected 0", bus.data_req); end
    n_checks++; if (load_done !== 1'b0) begin n_fail++; $display("FAIL misalign_done: got %b expected 0", load_done); end
`else
    exp_q.push_back(32'h89AB_CDEF);
    issue_load(LD_LW, 32'h0000_7002, 32'h89AB_CDEF, 0, 1, 0, 0);
    n_checks++; if (o_addr !== 32'h0000_7000) begin n_fail++; $display("FAIL misalign_addr: got %h expected 00007000", o_addr); end
    n_checks++; if (o_adel != 0) begin n_fail++; $display("FAIL misalign_adel: got %0d cycles expected 0", o_adel); end
    n_checks++; if (o_done != 1) begin n_fail++; $display("FAIL misalign_done: got %0d expected 1", o_done); end
`endif
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    load = 1'b1; load_con = LD_LW; addr = 32'h0000_8000; flush = 1'b0;
    @(negedge clk);
    bus.data_addr_ok = 1'b1;
    @(negedge clk);
    bus.data_addr_ok = 1'b0;
    rst = 1'b1; load = 1'b0;
    #1;
    n_checks++; if (bus.data_req !== 1'b0) begin n_fail++; $display("FAIL reset_mid_req: got %b expected 0", bus.data_req); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_mid_stall: got %b expected 0", stall); end
    n_checks++; if (bus.data_addr !== 32'h0) begin n_fail++; $display("FAIL reset_mid_addr: got %h expected 0", bus.data_addr); end
    @(negedge clk);
    rst = 1'b0;
    exp_q.push_back(32'hFFFF_FF9C);
    issue_load(LD_LB, 32'h0000_8002, 32'h009C_0000, 0, 1, 0, 0);
    n_checks++; if (o_lat != 3) begin n_fail++; $display("FAIL reset_mid_next_latency: got %0d expected 3", o_lat); end
  endtask

  initial begin
    test_reset();
    test_lb();
    test_half();
    test_patterns();
    test_random();
    test_delayed();
    test_flush_addr_ok();
    test_flush_req();
    test_flush_wait();
    test_misalign();
    test_reset_mid();
    repeat (3) @(negedge clk);
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d results outstanding, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
